// File: rtl/parallel_vector_divider_if.sv
// Handshake and lane bundle for the four-lane divider.
// Master drives start/operands; slave returns results.
interface parallel_vector_divider_if #(
  parameter int DIVIDEND_W = 16,
  parameter int DIVISOR_W  = 8
);
  logic                  start;
  logic [DIVIDEND_W-1:0] dividend1;
  logic [DIVIDEND_W-1:0] dividend2;
  logic [DIVIDEND_W-1:0] dividend3;
  logic [DIVIDEND_W-1:0] dividend4;
  logic [DIVISOR_W-1:0]  divisor1;
  logic [DIVISOR_W-1:0]  divisor2;
  logic [DIVISOR_W-1:0]  divisor3;
  logic [DIVISOR_W-1:0]  divisor4;
  logic [DIVIDEND_W-1:0] quotient1;
  logic [DIVIDEND_W-1:0] quotient2;
  logic [DIVIDEND_W-1:0] quotient3;
  logic [DIVIDEND_W-1:0] quotient4;
  logic [DIVISOR_W-1:0]  remainder1;
  logic [DIVISOR_W-1:0]  remainder2;
  logic [DIVISOR_W-1:0]  remainder3;
  logic [DIVISOR_W-1:0]  remainder4;
  logic [3:0]            div_zero;
  logic                  busy;
  logic                  done;

  modport master (
    output start,
    output dividend1, dividend2,
    output dividend3, dividend4,
    output divisor1, divisor2,
    output divisor3, divisor4,
    input  quotient1, quotient2,
    input  quotient3, quotient4,
    input  remainder1, remainder2,
    input  remainder3, remainder4,
    input  div_zero, busy, done
  );

  modport slave (
    input  start,
    input  dividend1, dividend2,
    input  dividend3, dividend4,
    input  divisor1, divisor2,
    input  divisor3, divisor4,
    output quotient1, quotient2,
    output quotient3, quotient4,
    output remainder1, remainder2,
    output remainder3, remainder4,
    output div_zero, busy, done
  );
endinterface

// File: rtl/parallel_vector_divider.sv
// Four-lane sequential restoring divider.
// One quotient bit per lane per CALC cycle, lanes in lockstep.
module parallel_vector_divider #(
  parameter int DIVIDEND_W = 16,
  parameter int DIVISOR_W  = 8
) (
  input  logic clk,
  input  logic reset,
  parallel_vector_divider_if.slave bus
);

  localparam int N     = 4;
  localparam int CNT_W = $clog2(DIVIDEND_W);
  localparam int PW    = DIVISOR_W + 1;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  state_t state;
  state_t state_nx;

  logic [CNT_W-1:0]      cnt;
  logic [DIVIDEND_W-1:0] dvd_q  [N];
  logic [DIVIDEND_W-1:0] dvd_nx [N];
  logic [DIVIDEND_W-1:0] quo_q  [N];
  logic [DIVIDEND_W-1:0] quo_nx [N];
  logic [DIVIDEND_W-1:0] q_out  [N];
  logic [DIVISOR_W-1:0]  dvs_q  [N];
  logic [DIVISOR_W-1:0]  rem_q  [N];
  logic [DIVISOR_W-1:0]  rem_nx [N];
  logic [DIVISOR_W-1:0]  r_out  [N];
  logic [PW-1:0]         part   [N];
  logic [PW-1:0]         diff   [N];
  logic [N-1:0]          ge;
  logic [N-1:0]          dz_q;
  logic [DIVIDEND_W-1:0] dvd_in [N];
  logic [DIVISOR_W-1:0]  dvs_in [N];

  logic accept;
  logic last;

  assign dvd_in[0] = bus.dividend1;
  assign dvd_in[1] = bus.dividend2;
  assign dvd_in[2] = bus.dividend3;
  assign dvd_in[3] = bus.dividend4;
  assign dvs_in[0] = bus.divisor1;
  assign dvs_in[1] = bus.divisor2;
  assign dvs_in[2] = bus.divisor3;
  assign dvs_in[3] = bus.divisor4;

  assign accept = (state == IDLE) && bus.start;
  assign last   = (state == CALC) &&
                  (cnt == CNT_W'(DIVIDEND_W - 1));

  // A zero divisor always compares ge, so the quotient
  // fills with ones and rem ends up as the dividend low bits.
  always_comb begin
    for (int i = 0; i < N; i++) begin
      part[i]   = {rem_q[i], dvd_q[i][DIVIDEND_W-1]};
      diff[i]   = part[i] - {1'b0, dvs_q[i]};
      ge[i]     = part[i] >= {1'b0, dvs_q[i]};
      rem_nx[i] = ge[i] ? diff[i][DIVISOR_W-1:0]
                        : part[i][DIVISOR_W-1:0];
      quo_nx[i] = {quo_q[i][DIVIDEND_W-2:0], ge[i]};
      dvd_nx[i] = dvd_q[i] << 1;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (bus.start) state_nx = CALC;
      CALC: if (last) state_nx = DONE;
      DONE: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
      for (int i = 0; i < N; i++) begin
        dvd_q[i] <= '0;
        dvs_q[i] <= '0;
        rem_q[i] <= '0;
        quo_q[i] <= '0;
      end
    end else if (accept) begin
      cnt <= '0;
      for (int i = 0; i < N; i++) begin
        dvd_q[i] <= dvd_in[i];
        dvs_q[i] <= dvs_in[i];
        rem_q[i] <= '0;
        quo_q[i] <= '0;
      end
    end else if (state == CALC) begin
      cnt <= cnt + 1'b1;
      for (int i = 0; i < N; i++) begin
        dvd_q[i] <= dvd_nx[i];
        rem_q[i] <= rem_nx[i];
        quo_q[i] <= quo_nx[i];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dz_q <= '0;
      for (int i = 0; i < N; i++) begin
        q_out[i] <= '0;
        r_out[i] <= '0;
      end
    end else if (last) begin
      for (int i = 0; i < N; i++) begin
        q_out[i] <= quo_nx[i];
        r_out[i] <= rem_nx[i];
        dz_q[i]  <= (dvs_q[i] == '0);
      end
    end
  end

  assign bus.quotient1  = q_out[0];
  assign bus.quotient2  = q_out[1];
  assign bus.quotient3  = q_out[2];
  assign bus.quotient4  = q_out[3];
  assign bus.remainder1 = r_out[0];
  assign bus.remainder2 = r_out[1];
  assign bus.remainder3 = r_out[2];
  assign bus.remainder4 = r_out[3];
  assign bus.div_zero   = dz_q;
  assign bus.busy       = (state == CALC);
  assign bus.done       = (state == DONE);

endmodule

// File: tb/tb_parallel_vector_divider.sv
// Bench for parallel_vector_divider: vector table,
// scoreboard queue, hand sequences for corner cases.
module tb_parallel_vector_divider;

  localparam int DW = 16;
  localparam int SW = 8;

  logic clk = 1'b0;
  logic reset = 1'b0;

  always #5 clk = ~clk;

  parallel_vector_divider_if #(
    .DIVIDEND_W(DW),
    .DIVISOR_W(SW)
  ) bus ();

  parallel_vector_divider #(
    .DIVIDEND_W(DW),
    .DIVISOR_W(SW)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  // lane 4 is the leftmost element of every concatenation
  typedef struct packed {
    logic [3:0][15:0] dvd;
    logic [3:0][7:0]  dvs;
    logic [3:0][15:0] q;
    logic [3:0][7:0]  r;
    logic [3:0]       dz;
  } vec_t;

  vec_t sb[$];
  int   sb_cyc[$];
  vec_t tbl[4];

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  int done_cnt = 0;

  always @(posedge clk) cyc++;

  task automatic check(input string name,
                       input logic [63:0] act,
                       input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h",
               name, act, exp);
    end
  endtask

  function automatic vec_t model(
    input logic [3:0][15:0] d,
    input logic [3:0][7:0] s);
    vec_t v;
    logic [15:0] m;
    v = '0;
    v.dvd = d;
    v.dvs = s;
    for (int i = 0; i < 4; i++) begin
      if (s[i] == 8'h00) begin
        v.q[i]  = 16'hFFFF;
        v.r[i]  = d[i][7:0];
        v.dz[i] = 1'b1;
      end else begin
        v.q[i] = d[i] / {8'h00, s[i]};
        m      = d[i] % {8'h00, s[i]};
        v.r[i] = m[7:0];
      end
    end
    return v;
  endfunction

  vec_t             mon_e;
  int               mon_c;
  logic [3:0][15:0] aq;
  logic [3:0][7:0]  ar;
  logic [31:0]      prod;

  always @(negedge clk) begin
    if (reset && bus.done) begin
      done_cnt++;
      check("busy_with_done", bus.busy, 1'b0);
      if (sb.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_done at cycle %0d", cyc);
      end else begin
        mon_e = sb.pop_front();
        mon_c = sb_cyc.pop_front();
        check("latency", cyc, mon_c);
        aq = {bus.quotient4, bus.quotient3,
              bus.quotient2, bus.quotient1};
        ar = {bus.remainder4, bus.remainder3,
              bus.remainder2, bus.remainder1};
        check("div_zero", bus.div_zero, mon_e.dz);
        for (int i = 0; i < 4; i++) begin
          check($sformatf("quotient%0d", i + 1),
                aq[i], mon_e.q[i]);
          check($sformatf("remainder%0d", i + 1),
                ar[i], mon_e.r[i]);
          if (mon_e.dvs[i] != 8'h00) begin
            prod = 32'(aq[i]) * 32'(mon_e.dvs[i])
                 + 32'(ar[i]);
            check($sformatf("q*d+r_lane%0d", i + 1),
                  prod, 32'(mon_e.dvd[i]));
            check($sformatf("r<d_lane%0d", i + 1),
                  ar[i] < mon_e.dvs[i], 1'b1);
          end
        end
      end
    end
  end

  task automatic set_ops(input vec_t v);
    {bus.dividend4, bus.dividend3,
     bus.dividend2, bus.dividend1} = v.dvd;
    {bus.divisor4, bus.divisor3,
     bus.divisor2, bus.divisor1} = v.dvs;
  endtask

  task automatic scramble();
    bus.dividend1 = 16'($urandom);
    bus.dividend2 = 16'($urandom);
    bus.dividend3 = 16'($urandom);
    bus.dividend4 = 16'($urandom);
    bus.divisor1  = 8'($urandom);
    bus.divisor2  = 8'($urandom);
    bus.divisor3  = 8'($urandom);
    bus.divisor4  = 8'($urandom);
  endtask

  // call at a negedge; returns at the negedge after E0
  task automatic launch(input vec_t v);
    set_ops(v);
    bus.start = 1'b1;
    sb.push_back(v);
    sb_cyc.push_back(cyc + 17);
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    scramble();
  endtask

  // returns at the negedge after DONE has left
  task automatic wait_done();
    for (int k = 0; k < 40 && !bus.done; k++)
      @(negedge clk);
    check("done_seen", bus.done, 1'b1);
    @(negedge clk);
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t vA;
    vec_t vB;
    vec_t v;
    logic [3:0][15:0] d;
    logic [3:0][7:0]  s;
    int   d0;
    logic seen;

    tbl[0] = '{dvd: {16'h0000, 16'hFFFF, 16'd1000, 16'h3F01},
               dvs: {8'h05, 8'h01, 8'h07, 8'h7F},
               q:   {16'h0000, 16'hFFFF, 16'h008E, 16'h007F},
               r:   {8'h00, 8'h00, 8'h06, 8'h00},
               dz:  4'b0000};
    tbl[1] = '{dvd: {16'h0100, 16'h0100, 16'h1234, 16'h0100},
               dvs: {8'h10, 8'h10, 8'h00, 8'h10},
               q:   {16'h0010, 16'h0010, 16'hFFFF, 16'h0010},
               r:   {8'h00, 8'h00, 8'h34, 8'h00},
               dz:  4'b0010};
    tbl[2] = '{dvd: {16'hABCD, 16'h8000, 16'h00FE, 16'hFFFF},
               dvs: {8'h80, 8'h03, 8'hFF, 8'hFF},
               q:   {16'h0157, 16'h2AAA, 16'h0000, 16'h0101},
               r:   {8'h4D, 8'h02, 8'hFE, 8'h00},
               dz:  4'b0000};
    tbl[3] = '{dvd: {16'hFFFF, 16'h0000, 16'h00FF, 16'h1234},
               dvs: {8'h00, 8'h00, 8'h01, 8'h12},
               q:   {16'hFFFF, 16'hFFFF, 16'h00FF, 16'h0102},
               r:   {8'hFF, 8'h00, 8'h00, 8'h10},
               dz:  4'b1100};

    bus.start = 1'b0;
    set_ops('0);

    #12;
    check("rst_quotients",
          {bus.quotient4, bus.quotient3,
           bus.quotient2, bus.quotient1}, 64'h0);
    check("rst_remainders",
          {bus.remainder4, bus.remainder3,
           bus.remainder2, bus.remainder1}, 64'h0);
    check("rst_flags",
          {bus.div_zero, bus.busy, bus.done}, 6'h0);

    @(negedge clk);
    reset = 1'b1;
    seen = 1'b0;
    repeat (20) begin
      @(negedge clk);
      seen |= bus.busy | bus.done;
    end
    check("idle_quiet", seen, 1'b0);

    for (int i = 0; i < 4; i++) begin
      launch(tbl[i]);
      wait_done();
    end

    d = {16'h4000, 16'h0FFF, 16'h7777, 16'h9999};
    s = {8'h20, 8'h0F, 8'h11, 8'h99};
    vA = model(d, s);
    d = {16'h1111, 16'h2222, 16'h3333, 16'h4444};
    s = {8'h03, 8'h05, 8'h07, 8'h09};
    vB = model(d, s);
    d0 = done_cnt;
    launch(vA);
    repeat (4) @(posedge clk);
    @(negedge clk);
    check("busy_in_calc", {bus.busy, bus.done}, 2'b10);
    set_ops(vB);
    bus.start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    set_ops(vB);
    bus.start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    check("done_at_e16", {bus.busy, bus.done}, 2'b01);
    @(negedge clk);
    check("idle_after_done", {bus.busy, bus.done}, 2'b00);
    repeat (3) @(negedge clk);
    check("ignored_start_no_busy", bus.busy, 1'b0);
    check("single_done", done_cnt - d0, 1);

    launch(tbl[2]);
    repeat (8) @(posedge clk);
    #2 reset = 1'b0;
    #1;
    check("midrst_flags",
          {bus.div_zero, bus.busy, bus.done}, 6'h0);
    check("midrst_quotients",
          {bus.quotient4, bus.quotient3,
           bus.quotient2, bus.quotient1}, 64'h0);
    check("midrst_remainders",
          {bus.remainder4, bus.remainder3,
           bus.remainder2, bus.remainder1}, 64'h0);
    sb.delete();
    sb_cyc.delete();
    @(negedge clk);
    reset = 1'b1;
    d0 = done_cnt;
    repeat (20) @(negedge clk);
    check("no_done_after_rst", done_cnt - d0, 0);
    launch(tbl[0]);
    wait_done();

    for (int k = 0; k < 200; k++) begin
      if (k == 0) begin
        d = {4{16'hFFFF}};
        s = {4{8'hFF}};
      end else if (k == 1) begin
        d = {4{16'h00FE}};
        s = {4{8'hFF}};
      end else begin
        for (int i = 0; i < 4; i++) begin
          d[i] = 16'($urandom);
          s[i] = 8'($urandom_range(0, 255));
        end
      end
      v = model(d, s);
      launch(v);
      wait_done();
    end

    repeat (3) @(negedge clk);
    check("scoreboard_drained", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
